// File: rtl/mod_swapchain.sv
// mod_swapchain: two-segment read selector with loop control.
// Switches segment on index wrap, system time or a gpio edge.
module mod_swapchain #(
  parameter int IdxWidth = 15
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                UPDATE_SETTINGS,
  input  logic                REQ_RD_SEGMENT,
  input  logic [15:0]         REP,
  input  logic [7:0]          TRANSITION_MODE,
  input  logic [63:0]         TRANSITION_VALUE,
  input  logic [63:0]         SYS_TIME,
  input  logic [3:0]          GPIO_IN,
  input  logic [IdxWidth-1:0] IDX0,
  input  logic [IdxWidth-1:0] IDX1,
  output logic                SEGMENT,
  output logic                STOP
);

  localparam logic [1:0] ST_WAIT = 2'd0;
  localparam logic [1:0] ST_FIN  = 2'd1;
  localparam logic [1:0] ST_INF  = 2'd2;

  localparam logic [7:0] MD_SYNC = 8'h00;
  localparam logic [7:0] MD_TIME = 8'h01;
  localparam logic [7:0] MD_GPIO = 8'h02;
  localparam logic [7:0] MD_EXT  = 8'hF0;

  localparam logic [15:0] REP_INF = 16'hFFFF;

  logic [1:0]          r_state;
  logic [1:0]          w_state_nxt;
  logic                r_req_seg;
  logic [15:0]         r_rep;
  logic [7:0]          r_mode;
  logic [63:0]         r_tval;
  logic [1:0]          r_gsel;
  logic                r_gpio_prev;
  logic [IdxWidth-1:0] r_idx0_prev;
  logic [IdxWidth-1:0] r_idx1_prev;
  logic [15:0]         r_cnt;

  logic        w_wrap0;
  logic        w_wrap1;
  logic        w_wrap_req;
  logic        w_wrap_act;
  logic [1:0]  w_gsel_nxt;
  logic        w_gpio_rise;
  logic        w_trig;
  logic        w_same_seg;
  logic [16:0] w_cnt_inc;
  logic        w_hit;
  logic        w_seg_nxt;
  logic        w_stop_nxt;
  logic [15:0] w_cnt_nxt;

  assign w_wrap0     = (r_idx0_prev != '0) && (IDX0 == '0);
  assign w_wrap1     = (r_idx1_prev != '0) && (IDX1 == '0);
  assign w_wrap_req  = r_req_seg ? w_wrap1 : w_wrap0;
  assign w_wrap_act  = SEGMENT ? w_wrap1 : w_wrap0;
  assign w_gsel_nxt  = UPDATE_SETTINGS ? TRANSITION_VALUE[1:0] : r_gsel;
  assign w_gpio_rise = GPIO_IN[r_gsel] & ~r_gpio_prev;
  assign w_same_seg  = (REQ_RD_SEGMENT == SEGMENT);
  assign w_cnt_inc   = {1'b0, r_cnt} + 17'd1;
  assign w_hit       = (w_cnt_inc >= {1'b0, r_rep});

  // Select the pending-transition trigger for the latched mode
  always_comb begin
    w_trig = w_wrap_req;
    unique case (r_mode)
      MD_TIME: w_trig = (SYS_TIME >= r_tval);
      MD_GPIO: w_trig = w_gpio_rise;
      MD_SYNC: w_trig = w_wrap_req;
      MD_EXT:  w_trig = w_wrap_req;
      default: w_trig = w_wrap_req;
    endcase
  end

  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= ST_INF;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic; a new request always wins over a wrap
  always_comb begin
    w_state_nxt = r_state;
    if (UPDATE_SETTINGS) begin
      if (!w_same_seg)         w_state_nxt = ST_WAIT;
      else if (REP == REP_INF) w_state_nxt = ST_INF;
      else                     w_state_nxt = ST_FIN;
    end else if (r_state == ST_WAIT && w_trig) begin
      w_state_nxt = (r_rep == REP_INF) ? ST_INF : ST_FIN;
    end
  end

  // Next values of segment, stop flag and loop counter
  always_comb begin
    w_seg_nxt  = SEGMENT;
    w_stop_nxt = STOP;
    w_cnt_nxt  = r_cnt;
    if (UPDATE_SETTINGS) begin
      w_stop_nxt = 1'b0;
      w_cnt_nxt  = 16'd0;
    end else begin
      case (r_state)
        ST_WAIT: begin
          if (w_trig) begin
            w_seg_nxt  = ~SEGMENT;
            w_stop_nxt = 1'b0;
            w_cnt_nxt  = 16'd0;
          end
        end
        ST_FIN: begin
          if (w_wrap_act && !STOP) begin
            w_cnt_nxt = w_cnt_inc[15:0];
            if (w_hit) w_stop_nxt = 1'b1;
          end
        end
        ST_INF: begin
          if (r_mode == MD_EXT && w_wrap_act)
            w_seg_nxt = ~SEGMENT;
        end
        default: w_seg_nxt = SEGMENT;
      endcase
    end
  end

  // Output and counter registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      SEGMENT <= 1'b0;
      STOP    <= 1'b0;
      r_cnt   <= 16'd0;
    end else begin
      SEGMENT <= w_seg_nxt;
      STOP    <= w_stop_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Latch request settings and track previous index / pin levels
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_req_seg   <= 1'b0;
      r_rep       <= REP_INF;
      r_mode      <= MD_SYNC;
      r_tval      <= 64'd0;
      r_gsel      <= 2'd0;
      r_gpio_prev <= 1'b0;
      r_idx0_prev <= '0;
      r_idx1_prev <= '0;
    end else begin
      if (UPDATE_SETTINGS) begin
        r_req_seg <= REQ_RD_SEGMENT;
        r_rep     <= REP;
        r_mode    <= TRANSITION_MODE;
        r_tval    <= TRANSITION_VALUE;
        r_gsel    <= TRANSITION_VALUE[1:0];
      end
      r_gpio_prev <= GPIO_IN[w_gsel_nxt];
      r_idx0_prev <= IDX0;
      r_idx1_prev <= IDX1;
    end
  end

endmodule

// File: tb/tb_mod_swapchain.sv
// tb_mod_swapchain: directed scenario bench for mod_swapchain.
// Each task drives one scenario and checks SEGMENT/STOP inline.
module tb_mod_swapchain;

  logic        clk = 1'b0;
  logic        rst;
  logic        upd;
  logic        req_seg;
  logic [15:0] rep;
  logic [7:0]  mode;
  logic [63:0] tval;
  logic [63:0] sys_time;
  logic [3:0]  gpio;
  logic [14:0] idx0;
  logic [14:0] idx1;
  logic        seg;
  logic        stop;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mod_swapchain #(.IdxWidth(15)) dut (
    .CLK(clk),
    .RST(rst),
    .UPDATE_SETTINGS(upd),
    .REQ_RD_SEGMENT(req_seg),
    .REP(rep),
    .TRANSITION_MODE(mode),
    .TRANSITION_VALUE(tval),
    .SYS_TIME(sys_time),
    .GPIO_IN(gpio),
    .IDX0(idx0),
    .IDX1(idx1),
    .SEGMENT(seg),
    .STOP(stop)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    upd = 1'b0;
    req_seg = 1'b0;
    rep = 16'hFFFF;
    mode = 8'h00;
    tval = 64'd0;
    sys_time = 64'd0;
    gpio = 4'd0;
    idx0 = 15'd0;
    idx1 = 15'd0;
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic req(input logic s, input logic [15:0] r,
                     input logic [7:0] m, input logic [63:0] v);
    upd = 1'b1;
    req_seg = s;
    rep = r;
    mode = m;
    tval = v;
    step();
    upd = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    upd = 1'b0;
    req_seg = 1'b0;
    rep = 16'h0;
    mode = 8'h00;
    tval = 64'd0;
    sys_time = 64'd0;
    gpio = 4'd0;
    idx0 = 15'd0;
    idx1 = 15'd0;
    #2;
    total++;
    if ({seg, stop} !== 2'b00) begin
      bad++;
      $display("FAIL reset_async got=%b exp=00", {seg, stop});
    end
    step();
    rst = 1'b0;
    total++;
    if ({seg, stop} !== 2'b00) begin
      bad++;
      $display("FAIL reset_hold got=%b exp=00", {seg, stop});
    end
  endtask

  task automatic test_idle();
    do_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 10; i++) begin
        idx0 = 15'(i);
        step();
        total++;
        if ({seg, stop} !== 2'b00) begin
          bad++;
          $display("FAIL idle i=%0d got=%b exp=00", i, {seg, stop});
        end
      end
    end
  endtask

  task automatic test_sync_idx();
    do_reset();
    req(1'b1, 16'hFFFF, 8'h00, 64'd0);
    for (int i = 1; i < 5; i++) begin
      idx1 = 15'(i);
      step();
      total++;
      if (seg !== 1'b0) begin
        bad++;
        $display("FAIL sync_early i=%0d got=%b exp=0", i, seg);
      end
    end
    idx1 = 15'd0;
    step();
    total++;
    if ({seg, stop} !== 2'b10) begin
      bad++;
      $display("FAIL sync_switch got=%b exp=10", {seg, stop});
    end
    for (int i = 1; i < 5; i++) begin
      idx1 = 15'(i);
      step();
    end
    idx1 = 15'd0;
    step();
    step();
    total++;
    if (seg !== 1'b1) begin
      bad++;
      $display("FAIL sync_hold got=%b exp=1", seg);
    end
  endtask

  task automatic test_sys_time();
    do_reset();
    req(1'b1, 16'hFFFF, 8'h01, 64'd1000);
    for (int t = 10; t <= 1020; t += 10) begin
      sys_time = 64'(t);
      step();
      if (t >= 980) begin
        total++;
        if (seg !== (t >= 1000)) begin
          bad++;
          $display("FAIL time t=%0d got=%b exp=%b", t, seg, t >= 1000);
        end
      end
    end
    req(1'b0, 16'hFFFF, 8'h01, 64'd5);
    total++;
    if (seg !== 1'b1) begin
      bad++;
      $display("FAIL time_past_upd got=%b exp=1", seg);
    end
    step();
    total++;
    if (seg !== 1'b0) begin
      bad++;
      $display("FAIL time_past_sw got=%b exp=0", seg);
    end
  endtask

  task automatic test_gpio();
    do_reset();
    gpio = 4'b0100;
    step();
    req(1'b1, 16'hFFFF, 8'h02, 64'd2);
    gpio = 4'b0101;
    step();
    gpio = 4'b0100;
    step();
    step();
    total++;
    if (seg !== 1'b0) begin
      bad++;
      $display("FAIL gpio_level got=%b exp=0", seg);
    end
    gpio = 4'b0000;
    step();
    total++;
    if (seg !== 1'b0) begin
      bad++;
      $display("FAIL gpio_low got=%b exp=0", seg);
    end
    gpio = 4'b0100;
    step();
    total++;
    if (seg !== 1'b1) begin
      bad++;
      $display("FAIL gpio_rise got=%b exp=1", seg);
    end
  endtask

  task automatic test_finite();
    do_reset();
    req(1'b1, 16'd2, 8'h00, 64'd0);
    for (int w = 0; w < 3; w++) begin
      for (int i = 1; i < 5; i++) begin
        idx1 = 15'(i);
        step();
      end
      idx1 = 15'd0;
      step();
      total++;
      if ({seg, stop} !== {1'b1, w == 2}) begin
        bad++;
        $display("FAIL finite w=%0d got=%b exp=%b", w, {seg, stop},
                 {1'b1, w == 2});
      end
    end
    idx1 = 15'd3;
    step();
    idx1 = 15'd0;
    step();
    total++;
    if (stop !== 1'b1) begin
      bad++;
      $display("FAIL finite_sticky got=%b exp=1", stop);
    end
    req(1'b1, 16'hFFFF, 8'h00, 64'd0);
    total++;
    if ({seg, stop} !== 2'b10) begin
      bad++;
      $display("FAIL finite_clear got=%b exp=10", {seg, stop});
    end
  endtask

  task automatic test_rep_zero();
    do_reset();
    req(1'b1, 16'd0, 8'h00, 64'd0);
    idx1 = 15'd3;
    step();
    idx1 = 15'd0;
    step();
    idx1 = 15'd2;
    step();
    total++;
    if ({seg, stop} !== 2'b10) begin
      bad++;
      $display("FAIL rep0_pre got=%b exp=10", {seg, stop});
    end
    idx1 = 15'd0;
    step();
    total++;
    if ({seg, stop} !== 2'b11) begin
      bad++;
      $display("FAIL rep0_stop got=%b exp=11", {seg, stop});
    end
  endtask

  task automatic test_ext_toggle();
    do_reset();
    req(1'b0, 16'hFFFF, 8'hF0, 64'd0);
    idx0 = 15'd1;
    step();
    idx0 = 15'd0;
    step();
    total++;
    if (seg !== 1'b1) begin
      bad++;
      $display("FAIL ext_t1 got=%b exp=1", seg);
    end
    idx0 = 15'd2;
    step();
    idx0 = 15'd0;
    step();
    total++;
    if (seg !== 1'b1) begin
      bad++;
      $display("FAIL ext_inactive got=%b exp=1", seg);
    end
    idx1 = 15'd1;
    step();
    idx1 = 15'd0;
    step();
    total++;
    if (seg !== 1'b0) begin
      bad++;
      $display("FAIL ext_t2 got=%b exp=0", seg);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    req(1'b0, 16'hFFFF, 8'h00, 64'd0);
    req(1'b1, 16'hFFFF, 8'h00, 64'd0);
    idx1 = 15'd1;
    step();
    idx1 = 15'd2;
    step();
    req(1'b0, 16'hFFFF, 8'h00, 64'd0);
    for (int i = 3; i < 6; i++) begin
      idx1 = (i == 5) ? 15'd0 : 15'(i);
      step();
    end
    step();
    total++;
    if (seg !== 1'b0) begin
      bad++;
      $display("FAIL b2b got=%b exp=0", seg);
    end
  endtask

  task automatic test_update_wins();
    do_reset();
    req(1'b1, 16'hFFFF, 8'h00, 64'd0);
    idx1 = 15'd4;
    step();
    idx1 = 15'd0;
    req(1'b1, 16'hFFFF, 8'h00, 64'd0);
    step();
    total++;
    if (seg !== 1'b0) begin
      bad++;
      $display("FAIL upd_wins got=%b exp=0", seg);
    end
    idx1 = 15'd1;
    step();
    idx1 = 15'd0;
    step();
    total++;
    if (seg !== 1'b1) begin
      bad++;
      $display("FAIL upd_later got=%b exp=1", seg);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    req(1'b1, 16'hFFFF, 8'h00, 64'd0);
    idx1 = 15'd4;
    step();
    rst = 1'b1;
    idx1 = 15'd0;
    step();
    rst = 1'b0;
    step();
    idx1 = 15'd3;
    step();
    idx1 = 15'd0;
    step();
    total++;
    if ({seg, stop} !== 2'b00) begin
      bad++;
      $display("FAIL reset_mid got=%b exp=00", {seg, stop});
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_sync_idx();
    test_sys_time();
    test_gpio();
    test_finite();
    test_rep_zero();
    test_ext_toggle();
    test_back_to_back();
    test_update_wins();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
